// File: rtl/ysyx_201979054_axi4_master_if.sv
// AXI4 bus between the cache-side burst master and its slave.
// Transaction IDs exist on the bus but the master always drives them to zero.
interface ysyx_201979054_axi4_master_if #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32
);
    logic [3:0]              arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    logic [3:0]              awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/ysyx_201979054_axi4_master.sv
// AXI4 master for cache line fills / write-backs (INCR bursts) and single-beat uncached accesses.
// One transaction at a time; request fields are captured at start and drive the bus from registers.
module ysyx_201979054_axi4_master #(
    parameter int  AXI_ADDR_W  = 32,
    parameter int  AXI_DATA_W  = 32,
    parameter int  BLOCK_WORDS = 16,
    localparam int IDX_W       = $clog2(BLOCK_WORDS),
    localparam int STRB_W      = AXI_DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_start_read,
    input  logic                  i_start_write,
    input  logic                  i_start_read_nc,
    input  logic                  i_start_write_nc,
    input  logic [AXI_ADDR_W-1:0] i_addr,
    input  logic [AXI_DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0]     i_wstrb,
    output logic [IDX_W-1:0]      o_word_idx,
    output logic [AXI_DATA_W-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_read_last,
    output logic                  o_b_resp,
    output logic                  o_resp_err,
    output logic                  o_busy,
    ysyx_201979054_axi4_master_if.master axi
);

    localparam logic [2:0]            BEAT_SIZE = 3'($clog2(STRB_W));
    localparam logic [AXI_ADDR_W-1:0] LINE_OFF  = AXI_ADDR_W'(BLOCK_WORDS * STRB_W - 1);
    localparam logic [7:0]            LINE_LEN  = 8'(BLOCK_WORDS - 1);
    localparam logic [1:0]            BURST_INCR = 2'b01;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [7:0]            len_q;
    logic [STRB_W-1:0]     strb_q;
    logic                  err_acc;

    logic rd_start;
    logic wr_start;
    logic take;
    logic nc_sel;
    logic r_hs;
    logic w_hs;
    logic b_hs;
    logic last_beat;
    logic resp_bad;

    assign rd_start  = i_start_read | i_start_read_nc;
    assign wr_start  = i_start_write | i_start_write_nc;
    assign take      = (state == S_IDLE) && (rd_start || wr_start);
    // Writes win over reads; a cacheable pulse wins over an uncached one of the same direction.
    assign nc_sel    = wr_start ? (i_start_write_nc && !i_start_write)
                                : (i_start_read_nc && !i_start_read);
    assign r_hs      = (state == S_R) && axi.rvalid;
    assign w_hs      = (state == S_W) && axi.wready;
    assign b_hs      = (state == S_B) && axi.bvalid;
    assign last_beat = (8'(o_word_idx) == len_q);
    assign resp_bad  = (r_hs && (axi.rresp != 2'b00)) || (b_hs && (axi.bresp != 2'b00));

    assign axi.arid    = '0;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = BEAT_SIZE;
    assign axi.arburst = BURST_INCR;
    assign axi.awid    = '0;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = BEAT_SIZE;
    assign axi.awburst = BURST_INCR;
    assign axi.wdata   = i_wdata;
    assign axi.wstrb   = strb_q;
    assign axi.wlast   = (state == S_W) && last_beat;
    assign o_busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_start) begin
                    state_nxt = S_AW;
                end else if (rd_start) begin
                    state_nxt = S_AR;
                end
            end
            S_AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) state_nxt = S_R;
            end
            S_R: begin
                axi.rready = 1'b1;
                if (axi.rvalid && axi.rlast) state_nxt = S_IDLE;
            end
            S_AW: begin
                axi.awvalid = 1'b1;
                if (axi.awready) state_nxt = S_W;
            end
            S_W: begin
                axi.wvalid = 1'b1;
                if (axi.wready && last_beat) state_nxt = S_B;
            end
            S_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            addr_q      <= '0;
            len_q       <= '0;
            strb_q      <= '0;
            err_acc     <= 1'b0;
            o_word_idx  <= '0;
            o_rvalid    <= 1'b0;
            o_read_last <= 1'b0;
            o_b_resp    <= 1'b0;
            o_resp_err  <= 1'b0;
        end else begin
            o_rvalid    <= r_hs;
            o_read_last <= r_hs && axi.rlast;
            o_b_resp    <= b_hs;
            if (take) begin
                addr_q     <= nc_sel ? i_addr : (i_addr & ~LINE_OFF);
                len_q      <= nc_sel ? 8'd0 : LINE_LEN;
                strb_q     <= nc_sel ? i_wstrb : '1;
                err_acc    <= 1'b0;
                o_word_idx <= '0;
                o_resp_err <= 1'b0;
            end else begin
                // A read index moves on once its beat has been presented, so it labels o_rdata.
                if (o_rvalid || w_hs) o_word_idx <= o_word_idx + 1'b1;
                if (r_hs || b_hs) err_acc <= err_acc | resp_bad;
                if ((r_hs && axi.rlast) || b_hs) o_resp_err <= err_acc | resp_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_hs) o_rdata <= axi.rdata;
    end

endmodule

// File: tb/tb_ysyx_201979054_axi4_master.sv
// Bench for the AXI4 burst master: the bench acts as the AXI slave and cache,
// predicting each transaction from its request kind, address and slave responses.
module tb_ysyx_201979054_axi4_master;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = 16;
    localparam int LIMIT = 400;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          i_start_read = 1'b0;
    logic          i_start_write = 1'b0;
    logic          i_start_read_nc = 1'b0;
    logic          i_start_write_nc = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_wdata;
    logic [3:0]    i_wstrb = '0;
    logic [3:0]    o_word_idx;
    logic [DW-1:0] o_rdata;
    logic          o_rvalid, o_read_last, o_b_resp, o_resp_err, o_busy;

    logic [DW-1:0] wtab [BW];
    logic [DW-1:0] rtab [BW];
    int checks = 0;
    int fails  = 0;

    ysyx_201979054_axi4_master_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW)) bus ();

    ysyx_201979054_axi4_master #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .BLOCK_WORDS(BW)) dut (
        .clk(clk), .arst(arst),
        .i_start_read(i_start_read), .i_start_write(i_start_write),
        .i_start_read_nc(i_start_read_nc), .i_start_write_nc(i_start_write_nc),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_word_idx(o_word_idx), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
        .o_read_last(o_read_last), .o_b_resp(o_b_resp), .o_resp_err(o_resp_err),
        .o_busy(o_busy), .axi(bus)
    );

    always #5 clk = ~clk;

    // The cache supplies the word the master is currently pointing at.
    always_comb i_wdata = wtab[o_word_idx];

    task automatic run_read(input logic [AW-1:0] addr, input bit nc, input int ar_dly,
                            input int err_beat, input int stall, input bit poke, input int rst_at);
        logic [AW-1:0] exp_addr;
        int beats, sent, got, cyc;
        bit any_err, last_exp;
        exp_addr = nc ? addr : (addr & ~AW'(BW * 4 - 1));
        beats    = nc ? 1 : BW;
        any_err  = (err_beat >= 0) && (err_beat < beats);
        for (int i = 0; i < beats; i++) rtab[i] = $urandom;
        i_addr = addr; i_start_read = !nc; i_start_read_nc = nc;
        @(negedge clk);
        i_start_read = 0; i_start_read_nc = 0; i_addr = $urandom;
        checks++;
        if (bus.arvalid !== 1'b1 || o_resp_err !== 1'b0 || o_word_idx !== 4'd0) begin
            fails++;
            $display("FAIL rd_start arvalid=%b err=%b idx=%0d expected 1 0 0", bus.arvalid, o_resp_err, o_word_idx);
        end
        checks++;
        if ({bus.araddr, bus.arlen, bus.arsize, bus.arburst} !== {exp_addr, 8'(beats - 1), 3'd2, 2'b01}) begin
            fails++;
            $display("FAIL rd_ar_fields addr=%h len=%0d size=%0d burst=%0d expected %h %0d 2 1",
                     bus.araddr, bus.arlen, bus.arsize, bus.arburst, exp_addr, beats - 1);
        end
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk);
            checks++;
            if (bus.arvalid !== 1'b1 || bus.araddr !== exp_addr) begin
                fails++;
                $display("FAIL rd_ar_hold arvalid=%b addr=%h expected 1 %h", bus.arvalid, bus.araddr, exp_addr);
            end
        end
        bus.arready = 1;
        sent = 0; got = 0; cyc = 0;
        while (got < beats && cyc < LIMIT) begin
            @(negedge clk);
            bus.arready = 0;
            if (o_rvalid) begin
                last_exp = (got == beats - 1);
                checks++;
                if (got >= sent) begin
                    fails++;
                    $display("FAIL rd_spurious o_rvalid=1 with %0d beats sent and %0d seen", sent, got);
                end else if ({o_rdata, o_word_idx, o_read_last} !== {rtab[got], 4'(got % BW), last_exp}) begin
                    fails++;
                    $display("FAIL rd_beat%0d data=%h idx=%0d last=%b expected %h %0d %b",
                             got, o_rdata, o_word_idx, o_read_last, rtab[got], got % BW, last_exp);
                end
                if (last_exp) begin
                    checks++;
                    if (o_resp_err !== any_err) begin
                        fails++;
                        $display("FAIL rd_err o_resp_err=%b expected %b", o_resp_err, any_err);
                    end
                end
                got++;
            end
            i_start_write = poke && (cyc == 3);
            if (sent < beats && $urandom_range(0, 99) >= stall) begin
                bus.rvalid = 1; bus.rdata = rtab[sent]; bus.rlast = (sent == beats - 1);
                bus.rresp  = (sent == err_beat) ? 2'($urandom_range(2, 3)) : 2'b00;
                if (sent == rst_at) begin
                    #1 arst = 0;
                    #1;
                    checks++;
                    if ({o_busy, o_rvalid, o_read_last, o_b_resp, o_resp_err, bus.arvalid, bus.rready,
                         bus.awvalid, bus.wvalid, bus.bready} !== 10'd0 || o_word_idx !== 4'd0) begin
                        fails++;
                        $display("FAIL rst_async busy=%b rv=%b last=%b rready=%b idx=%0d expected all 0",
                                 o_busy, o_rvalid, o_read_last, bus.rready, o_word_idx);
                    end
                    bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0;
                    @(negedge clk);
                    checks++;
                    if (o_read_last !== 1'b0 || o_rvalid !== 1'b0 || o_busy !== 1'b0) begin
                        fails++;
                        $display("FAIL rst_hold last=%b rv=%b busy=%b expected 0 0 0", o_read_last, o_rvalid, o_busy);
                    end
                    arst = 1;
                    return;
                end
                sent++;
            end else begin
                bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0; bus.rdata = $urandom;
            end
            cyc++;
        end
        bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0; i_start_write = 0;
        checks++;
        if (got != beats) begin
            fails++;
            $display("FAIL rd_timeout beats=%0d expected %0d", got, beats);
        end
        checks++;
        if (o_busy !== 1'b0 || bus.arvalid !== 1'b0) begin
            fails++;
            $display("FAIL rd_idle busy=%b arvalid=%b expected 0 0", o_busy, bus.arvalid);
        end
        if (poke) begin
            @(negedge clk);
            checks++;
            if (bus.awvalid !== 1'b0 || o_busy !== 1'b0) begin
                fails++;
                $display("FAIL rd_poke awvalid=%b busy=%b expected 0 0", bus.awvalid, o_busy);
            end
        end
    endtask

    task automatic run_write(input logic [AW-1:0] addr, input bit nc, input logic [3:0] strb,
                             input int aw_dly, input int mode, input bit berr, input int b_dly,
                             input bit with_read);
        logic [AW-1:0] exp_addr;
        logic [3:0] exp_strb;
        int beats, beat, cyc;
        bit saw_ar, rdy, last_exp;
        exp_addr = nc ? addr : (addr & ~AW'(BW * 4 - 1));
        exp_strb = nc ? strb : 4'hF;
        beats    = nc ? 1 : BW;
        for (int i = 0; i < BW; i++) wtab[i] = $urandom;
        i_addr = addr; i_wstrb = strb;
        i_start_write = !nc; i_start_write_nc = nc; i_start_read = with_read;
        @(negedge clk);
        i_start_write = 0; i_start_write_nc = 0; i_start_read = 0;
        i_addr = $urandom; i_wstrb = 4'($urandom);
        checks++;
        if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b0 || o_resp_err !== 1'b0) begin
            fails++;
            $display("FAIL wr_start awvalid=%b wvalid=%b err=%b expected 1 0 0", bus.awvalid, bus.wvalid, o_resp_err);
        end
        checks++;
        if ({bus.awaddr, bus.awlen, bus.awsize, bus.awburst} !== {exp_addr, 8'(beats - 1), 3'd2, 2'b01}) begin
            fails++;
            $display("FAIL wr_aw_fields addr=%h len=%0d size=%0d burst=%0d expected %h %0d 2 1",
                     bus.awaddr, bus.awlen, bus.awsize, bus.awburst, exp_addr, beats - 1);
        end
        saw_ar = bus.arvalid;
        for (int i = 0; i < aw_dly; i++) begin
            @(negedge clk);
            saw_ar |= bus.arvalid;
            checks++;
            if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b0) begin
                fails++;
                $display("FAIL wr_aw_hold awvalid=%b wvalid=%b expected 1 0", bus.awvalid, bus.wvalid);
            end
        end
        bus.awready = 1;
        @(negedge clk);
        bus.awready = 0;
        beat = 0; cyc = 0;
        while (beat < beats && cyc < LIMIT) begin
            saw_ar |= bus.arvalid;
            last_exp = (beat == beats - 1);
            checks++;
            if (bus.wvalid !== 1'b1 || bus.wstrb !== exp_strb || o_word_idx !== 4'(beat)) begin
                fails++;
                $display("FAIL wr_ctl wvalid=%b strb=%h idx=%0d expected 1 %h %0d", bus.wvalid, bus.wstrb, o_word_idx, exp_strb, beat);
            end
            checks++;
            if (bus.wdata !== wtab[beat] || bus.wlast !== last_exp) begin
                fails++;
                $display("FAIL wr_beat%0d data=%h last=%b expected %h %b", beat, bus.wdata, bus.wlast, wtab[beat], last_exp);
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.wready = rdy;
            @(negedge clk);
            if (rdy) beat++;
            cyc++;
        end
        bus.wready = 0;
        checks++;
        if (beat != beats) begin
            fails++;
            $display("FAIL wr_timeout beats=%0d expected %0d", beat, beats);
        end
        checks++;
        if (bus.wvalid !== 1'b0 || bus.bready !== 1'b1 || o_b_resp !== 1'b0) begin
            fails++;
            $display("FAIL wr_b_state wvalid=%b bready=%b bresp_pulse=%b expected 0 1 0", bus.wvalid, bus.bready, o_b_resp);
        end
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            checks++;
            if (o_b_resp !== 1'b0 || bus.bready !== 1'b1) begin
                fails++;
                $display("FAIL wr_b_wait pulse=%b bready=%b expected 0 1", o_b_resp, bus.bready);
            end
        end
        bus.bvalid = 1; bus.bresp = berr ? 2'b10 : 2'b00;
        @(negedge clk);
        bus.bvalid = 0; bus.bresp = 0;
        checks++;
        if (o_b_resp !== 1'b1 || o_resp_err !== berr || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL wr_bresp pulse=%b err=%b busy=%b expected 1 %b 0", o_b_resp, o_resp_err, o_busy, berr);
        end
        saw_ar |= bus.arvalid;
        @(negedge clk);
        checks++;
        if (o_b_resp !== 1'b0 || bus.arvalid !== 1'b0 || saw_ar) begin
            fails++;
            $display("FAIL wr_after pulse=%b arvalid=%b saw_ar=%b expected 0 0 0", o_b_resp, bus.arvalid, saw_ar);
        end
    endtask

    task automatic test_reset();
        #1 arst = 0;
        #1;
        checks++;
        if ({o_busy, o_rvalid, o_read_last, o_b_resp, o_resp_err, o_word_idx, bus.arvalid, bus.rready,
             bus.awvalid, bus.wvalid, bus.bready, bus.arid, bus.awid} !== 22'd0) begin
            fails++;
            $display("FAIL reset_outputs busy=%b rv=%b idx=%0d arvalid=%b awvalid=%b expected all 0",
                     o_busy, o_rvalid, o_word_idx, bus.arvalid, bus.awvalid);
        end
        @(negedge clk);
        @(negedge clk);
        arst = 1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || bus.arvalid !== 1'b0 || bus.awvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle busy=%b arvalid=%b awvalid=%b expected 0 0 0", o_busy, bus.arvalid, bus.awvalid);
        end
    endtask

    task automatic test_read_burst();
        run_read(32'h8000_0044, 0, 3, -1, 0, 0, -1);
        @(negedge clk);
        run_read(32'h2000_0ABC, 1, 0, -1, 30, 0, -1);
    endtask

    task automatic test_write_burst();
        run_write(32'h8000_0100, 0, 4'h0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_write_nc();
        run_write(32'h1000_0003, 1, 4'h8, 1, 0, 0, 1, 0);
    endtask

    task automatic test_simultaneous();
        run_write(32'h8000_0200, 0, 4'h0, 0, 0, 0, 0, 1);
        run_read(32'h8000_0280, 0, 1, -1, 10, 1, -1);
    endtask

    task automatic test_resp_err();
        run_read(32'h8000_0300, 0, 0, 2, 20, 0, -1);
        run_read(32'h8000_0340, 1, 0, -1, 0, 0, -1);
        @(negedge clk);
        run_write(32'h8000_0400, 0, 4'h0, 2, 2, 1, 2, 0);
    endtask

    task automatic test_reset_mid_burst();
        run_read(32'h8000_0500, 0, 0, -1, 0, 0, 4);
        run_read(32'h8000_0540, 0, 2, -1, 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        run_read(32'h8000_0600, 0, 0, -1, 0, 0, -1);
        run_read(32'h8000_0640, 0, 0, -1, 0, 0, -1);
        run_write(32'h8000_0680, 1, 4'h3, 0, 0, 0, 0, 0);
        run_write(32'h8000_06C0, 0, 4'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int kind, beats;
        for (int t = 0; t < 24; t++) begin
            kind  = $urandom_range(0, 3);
            beats = kind[0] ? 1 : BW;
            if (kind < 2) begin
                run_read($urandom, kind[0], $urandom_range(0, 3),
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, beats - 1)) : -1,
                         $urandom_range(0, 40), 0, -1);
            end else begin
                run_write($urandom, kind[0], 4'($urandom), $urandom_range(0, 3), 2,
                          1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
        for (int i = 0; i < BW; i++) begin
            wtab[i] = '0;
            rtab[i] = '0;
        end
        test_reset();
        test_read_burst();
        @(negedge clk);
        test_write_burst();
        test_write_nc();
        test_simultaneous();
        @(negedge clk);
        test_resp_err();
        test_reset_mid_burst();
        @(negedge clk);
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
